tt_um_sum_display: RTL
======================

// Module: tt_um_sum_display
// PURPOSE
// - Consumer end of the sumador result path: takes the 8-bit sum presented on ui_in and shows it in decimal
//   on a 3-digit multiplexed 7-segment display.
// - Binary-to-BCD conversion is sequential (8-step shift-add-3). Digit refresh is time-multiplexed.
// - Same TinyTapeout top-level pin set as the rest of the design.
// PARAMETERS
// - REFRESH_DIV  1000  clk cycles each digit stays lit; legal range >= 2
// - SYNC_STAGES  2     flops in the synchroniser for uio_in[0]; legal range >= 2
// PORTS
// - clk      in   1  clock; single clock domain
// - rst_n    in   1  reset, asynchronous, active-low
// - ena      in   1  design enable; 0 = load requests ignored, refresh keeps running
// - ui_in    in   8  unsigned binary value to display, 0..255
// - uio_in   in   8  [0] = load request (async, rising edge); [7:1] unused
// - uo_out   out  8  [6:0] segments gfedcba, active-high; [7] = dp, tied 0
// - uio_out  out  8  [3:1] digit enables, one-hot, active-high: [1]=ones, [2]=tens, [3]=hundreds
//                    [4] = busy; [5] = valid; [0], [7:6] = 0
// - uio_oe   out  8  constant 8'b0011_1110
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE; BCD and display registers = 0; valid=0; busy=0; refresh counter=0; digit index=0.
//   - uo_out=0; uio_out=0.
// - Load detect: uio_in[0] passes through SYNC_STAGES flops, then a rising-edge detector.
//   - Edge acts only when state==IDLE and ena==1.
//   - An edge at any other time is dropped, not queued.
// - FSM IDLE -> CONV -> DONE -> IDLE
//   - IDLE: on edge-detect cycle E, capture ui_in into shift reg, clear BCD, go to CONV. busy=1 from E+1.
//   - CONV: 8 cycles (E+1..E+8). Each cycle:
//     - every BCD nibble >=5 gets +3;
//     - then {BCD[11:0], shift[7:0]} shifts left by 1.
//     - A 4-bit step counter runs 0..7; at 7 go to DONE.
//   - DONE: 1 cycle (E+9):
//     - display regs <= BCD; valid=1 (sticky until reset); busy=0 from E+10.
//     - Go to IDLE.
//   - Latency: edge detect to new digits visible = 10 cycles.
//   - BCD widths: hundreds nibble is 0..2; tens and ones are 0..9.
//   - ui_in changing during CONV has no effect.
// - Refresh:
//   - Counter runs 0..REFRESH_DIV-1. On wrap, digit index advances 0->1->2->0 (ones, tens, hundreds).
//   - Digit enable and segment pattern are registered together in the same cycle (no ghosting).
//   - While valid==0: enables=000 and segments=0.
//   - A display-register update mid-scan takes effect at the next registered output. Scan position is not reset.
// - Segment encoding, 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
// - Reset mid-CONV: conversion aborts immediately. Old display and valid are cleared, not kept.
// CONFIGURATION
// - Macro SUM_DISP_LEADING_BLANK_EN.
// - Defined:
//   - hundreds segments = 0 when hundreds == 0;
//   - tens segments = 0 when hundreds == 0 and tens == 0;
//   - ones digit is never blanked;
//   - digit enables are unaffected.
// - Undefined: all three digits always show their value, e.g. 7 displays as "007".
// TESTING
// - Reset: rst_n=0 mid-CONV -> next sample shows uo_out=0, uio_out=0, valid=0; after release state is IDLE.
// - ui_in=255, pulse uio_in[0] -> busy high 9 cycles; then valid=1, digits 2/5/5.
//   Hundreds slot shows 0x5B; tens and ones slots show 0x6D.
// - REFRESH_DIV=4, valid=1 -> uio_out[3:1] sequence 001,010,100,001..., each held exactly 4 cycles.
// - ui_in=7, load; then second load edge during CONV with ui_in=200 -> displays 0/0/7; second edge ignored.
// - Macro undefined, ui_in=7 -> segments 3F,3F,07.
//   Macro defined -> 00,00,07. ui_in=0 with macro -> 00,00,3F.
// - ena=0 with load edge -> busy stays 0, display unchanged; refresh continues.

Source files
------------

// File: rtl/tt_um_sum_display.sv
// tt_um_sum_display
//   Shows an 8-bit unsigned value from ui_in in decimal on a 3-digit
//   multiplexed 7-segment display. A rising edge on uio_in[0] starts a load.
//   The value is converted to BCD sequentially using 8 shift-add-3 steps.
//   The digits are then refreshed one at a time.
//
// Parameters
//   REFRESH_DIV  clk cycles each digit stays lit (>= 2)
//   SYNC_STAGES  synchroniser depth for uio_in[0] (>= 2)
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   ena      design enable; 0 blocks loads, refresh keeps running
//   ui_in    value to display, 0..255
//   uio_in   [0] load request (asynchronous, rising edge); [7:1] unused
//   uo_out   [6:0] segments gfedcba, active-high; [7] dp, tied 0
//   uio_out  [3:1] one-hot digit enables (ones, tens, hundreds),
//            [4] busy, [5] valid, others 0
//   uio_oe   constant 8'b0011_1110
//
// Configuration
//   SUM_DISP_LEADING_BLANK_EN  when defined, leading zeros in the hundreds
//   and tens digits are blanked. The ones digit is always shown.
module tt_um_sum_display #(
  parameter int REFRESH_DIV = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one.
  function automatic logic [19:0] conv_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_q;
  logic                   w_edge;
  logic [1:0]             r_state;
  logic [3:0]             r_step;
  logic [19:0]            r_conv;   // {hundreds, tens, ones, binary}
  logic [11:0]            r_disp;
  logic                   r_valid;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_cnt;
  logic [1:0]             r_dig;
  logic [2:0]             r_en;
  logic [6:0]             r_seg;
  logic [6:0]             w_seg;
  logic [2:0]             w_en;
  logic                   w_blank_h;
  logic                   w_blank_t;
  logic                   w_unused;

  assign w_unused = ^uio_in[7:1];

  // Load request synchroniser and rising-edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], uio_in[0]};
      r_sync_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_sync_q;

  // Conversion FSM. Edges outside IDLE, or with ena low, are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= 4'd0;
      r_conv  <= 20'd0;
      r_disp  <= 12'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_step <= 4'd0;
          if (w_edge && ena) begin
            r_conv  <= {12'd0, ui_in};
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_conv <= conv_step(r_conv);
          r_step <= r_step + 4'd1;
          if (r_step == 4'd7) r_state <= S_DONE;
        end
        S_DONE: begin
          r_disp  <= r_conv[19:8];
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Refresh timer and digit index (0 = ones, 1 = tens, 2 = hundreds)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_dig <= (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef SUM_DISP_LEADING_BLANK_EN
  assign w_blank_h = (r_disp[11:8] == 4'd0);
  assign w_blank_t = (r_disp[11:8] == 4'd0) && (r_disp[7:4] == 4'd0);
`else
  assign w_blank_h = 1'b0;
  assign w_blank_t = 1'b0;
`endif

  always_comb begin
    w_seg = 7'h00;
    w_en  = 3'b000;
    case (r_dig)
      2'd0: begin
        w_en  = 3'b001;
        w_seg = seg7(r_disp[3:0]);
      end
      2'd1: begin
        w_en  = 3'b010;
        w_seg = w_blank_t ? 7'h00 : seg7(r_disp[7:4]);
      end
      2'd2: begin
        w_en  = 3'b100;
        w_seg = w_blank_h ? 7'h00 : seg7(r_disp[11:8]);
      end
      default: begin
        w_en  = 3'b000;
        w_seg = 7'h00;
      end
    endcase
  end

  // Enable and segments are registered together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en  <= 3'b000;
      r_seg <= 7'h00;
    end else if (!r_valid) begin
      r_en  <= 3'b000;
      r_seg <= 7'h00;
    end else begin
      r_en  <= w_en;
      r_seg <= w_seg;
    end
  end

  assign uo_out  = {1'b0, r_seg};
  assign uio_out = {2'b00, r_valid, r_busy, r_en, 1'b0};
  assign uio_oe  = 8'b0011_1110;

endmodule
